// File: rtl/ddr2_init_sequencer_if.sv
// Device-side command/address pins driven by the DDR2 power-up sequencer,
// plus the completion flag handed to the main controller.
interface ddr2_init_sequencer_if;
  logic        cke;
  logic        csbar;
  logic        rasbar;
  logic        casbar;
  logic        webar;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        odt;
  logic        init_done;

  modport master (output cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done);
  modport slave  (input  cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done);
endinterface

// File: rtl/ddr2_init_sequencer.sv
// JEDEC DDR2 power-up sequencer: CKE hold-off, precharge, EMR2/EMR3/EMR/MR loads,
// DLL reset, two refreshes and OCD default/exit, then a sticky init_done.
module ddr2_init_sequencer #(
  parameter int unsigned T_INIT  = 53334,
  parameter int unsigned T_XPR   = 107,
  parameter int unsigned T_RP    = 4,
  parameter int unsigned T_MRD   = 2,
  parameter int unsigned T_RFC   = 28,
  parameter int unsigned T_DLL   = 200,
  parameter logic [12:0] MR_VAL  = 13'h0442,
  parameter logic [12:0] EMR_VAL = 13'h0004
) (
  input  logic                  clk,
  input  logic                  reset,
  ddr2_init_sequencer_if.master dram
);

  function automatic int unsigned max_of(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  localparam int unsigned T_MAX = max_of(max_of(max_of(T_INIT, T_XPR), max_of(T_RP, T_MRD)),
                                         max_of(T_RFC, T_DLL));
  localparam int CNT_W = $clog2(T_MAX + 1);
  localparam int DLL_W = $clog2(T_DLL + 1);

  // {cs, ras, cas, we}
  localparam logic [3:0]  CMD_NOP   = 4'b0111;
  localparam logic [3:0]  CMD_PRE   = 4'b0010;
  localparam logic [3:0]  CMD_MRS   = 4'b0000;
  localparam logic [3:0]  CMD_REF   = 4'b0001;
  localparam logic [3:0]  CMD_DESEL = 4'b1111;
  localparam logic [12:0] A10       = 13'h0400;

  typedef enum logic [3:0] {
    PWR_WAIT, CKE_NOP, PRE1, EMR2, EMR3, EMR_DLL, MR_DLLRST, PRE2,
    REF1, REF2, MR, OCD_DEF, OCD_EXIT, DLL_WAIT, DONE
  } state_t;

  typedef struct packed {
    logic [3:0]  pins;
    logic [1:0]  ba;
    logic [12:0] a;
  } cmd_t;

  // Cycles from a state's command (or entry) to the next state's command.
  function automatic logic [CNT_W-1:0] gap_of(input state_t s);
    case (s)
      PWR_WAIT:   return CNT_W'(T_INIT);
      CKE_NOP:    return CNT_W'(T_XPR);
      PRE1, PRE2: return CNT_W'(T_RP);
      REF1, REF2: return CNT_W'(T_RFC);
      default:    return CNT_W'(T_MRD);
    endcase
  endfunction

  // Command pulse issued on the edge that enters a state.
  function automatic cmd_t cmd_of(input state_t s);
    case (s)
      PRE1, PRE2: return {CMD_PRE, 2'd0, A10};
      EMR2:       return {CMD_MRS, 2'd2, 13'h0000};
      EMR3:       return {CMD_MRS, 2'd3, 13'h0000};
      EMR_DLL:    return {CMD_MRS, 2'd1, EMR_VAL};
      MR_DLLRST:  return {CMD_MRS, 2'd0, MR_VAL | 13'h0100};
      REF1, REF2: return {CMD_REF, 2'd0, 13'h0000};
      MR:         return {CMD_MRS, 2'd0, MR_VAL};
      OCD_DEF:    return {CMD_MRS, 2'd1, EMR_VAL | 13'h0380};
      OCD_EXIT:   return {CMD_MRS, 2'd1, EMR_VAL};
      default:    return {CMD_NOP, 2'd0, 13'h0000};
    endcase
  endfunction

  state_t            state_q;
  state_t            nxt_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DLL_W-1:0]  dll_q;
  logic              cke_q;
  logic [3:0]        pins_q;
  logic [1:0]        ba_q;
  logic [12:0]       a_q;
  logic              done_q;
  logic              adv_d;
  logic              dll_done;
  cmd_t              ent_d;

  assign dll_done = (dll_q == DLL_W'(T_DLL));

  always_comb begin
    nxt_d = DONE;
    case (state_q)
      PWR_WAIT:  nxt_d = CKE_NOP;
      CKE_NOP:   nxt_d = PRE1;
      PRE1:      nxt_d = EMR2;
      EMR2:      nxt_d = EMR3;
      EMR3:      nxt_d = EMR_DLL;
      EMR_DLL:   nxt_d = MR_DLLRST;
      MR_DLLRST: nxt_d = PRE2;
      PRE2:      nxt_d = REF1;
      REF1:      nxt_d = REF2;
      REF2:      nxt_d = MR;
      MR:        nxt_d = OCD_DEF;
      OCD_DEF:   nxt_d = OCD_EXIT;
      OCD_EXIT:  nxt_d = dll_done ? DONE : DLL_WAIT;
      default:   nxt_d = DONE;
    endcase

    adv_d = 1'b0;
    if (state_q == DLL_WAIT)  adv_d = dll_done;
    else if (state_q != DONE) adv_d = (cnt_q == gap_of(state_q));

    ent_d = cmd_of(nxt_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      dll_q   <= '0;
      cke_q   <= 1'b0;
      pins_q  <= CMD_DESEL;
      ba_q    <= 2'd0;
      a_q     <= 13'h0000;
      done_q  <= 1'b0;
    end else begin
      // The DLL counter starts at MR_DLLRST and saturates at T_DLL.
      if (dll_q != '0 && !dll_done) dll_q <= dll_q + DLL_W'(1);

      if (adv_d) begin
        state_q <= nxt_d;
        cnt_q   <= CNT_W'(1);
        pins_q  <= ent_d.pins;
        ba_q    <= ent_d.ba;
        a_q     <= ent_d.a;
        if (nxt_d == CKE_NOP)   cke_q  <= 1'b1;
        if (nxt_d == MR_DLLRST) dll_q  <= DLL_W'(1);
        if (nxt_d == DONE)      done_q <= 1'b1;
      end else begin
        if (state_q != DONE && state_q != DLL_WAIT) cnt_q <= cnt_q + CNT_W'(1);
        pins_q <= (state_q == PWR_WAIT) ? CMD_DESEL : CMD_NOP;
        ba_q   <= 2'd0;
        a_q    <= 13'h0000;
      end
    end
  end

  assign dram.cke       = cke_q;
  assign dram.csbar     = pins_q[3];
  assign dram.rasbar    = pins_q[2];
  assign dram.casbar    = pins_q[1];
  assign dram.webar     = pins_q[0];
  assign dram.ba        = ba_q;
  assign dram.a         = a_q;
  assign dram.odt       = 1'b0;
  assign dram.init_done = done_q;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Bench for ddr2_init_sequencer: four parameter sets under randomized reset pulses,
// compared every cycle against a command-schedule model and a pin protocol checker.
module tb_ddr2_init_sequencer;

  localparam int NDUT = 4;
  localparam int PI[NDUT] = '{10, 10, 2, 7};
  localparam int PX[NDUT] = '{4, 4, 2, 5};
  localparam int PR[NDUT] = '{3, 3, 2, 4};
  localparam int PM[NDUT] = '{2, 2, 2, 3};
  localparam int PF[NDUT] = '{8, 8, 2, 6};
  localparam int PD[NDUT] = '{20, 40, 2, 9};

  localparam logic [12:0] MRV  = 13'h0442;
  localparam logic [12:0] EMRV = 13'h0004;

  // Command list in issue order; entry i follows entry i-1 after the i-th gap.
  localparam logic [3:0]  SEQ_PIN[11] = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
  localparam logic [1:0]  SEQ_BA[11]  = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
  localparam logic [12:0] SEQ_A[11]   = '{13'h0400, 13'h0000, 13'h0000, EMRV, MRV | 13'h0100, 13'h0400,
                                          13'h0000, 13'h0000, MRV, EMRV | 13'h0380, EMRV};

  // Hand-computed pin vectors {cke, cs,ras,cas,we, ba, a, odt, init_done}.
  localparam int NL = 18;
  localparam int LG[NL] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  localparam int LC[NL] = '{9, 10, 14, 17, 19, 21, 23, 25, 28, 36, 44, 46, 48, 49, 50, 48, 62, 63};
  localparam logic [21:0] LV[NL] = '{
    {1'b0, 4'hF, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h7, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h2, 2'd0, 13'h0400, 2'b00},
    {1'b1, 4'h0, 2'd2, 13'h0000, 2'b00},
    {1'b1, 4'h0, 2'd3, 13'h0000, 2'b00},
    {1'b1, 4'h0, 2'd1, 13'h0004, 2'b00},
    {1'b1, 4'h0, 2'd0, 13'h0542, 2'b00},
    {1'b1, 4'h2, 2'd0, 13'h0400, 2'b00},
    {1'b1, 4'h1, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h1, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h0, 2'd0, 13'h0442, 2'b00},
    {1'b1, 4'h0, 2'd1, 13'h0384, 2'b00},
    {1'b1, 4'h0, 2'd1, 13'h0004, 2'b00},
    {1'b1, 4'h7, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h7, 2'd0, 13'h0000, 2'b01},
    {1'b1, 4'h0, 2'd1, 13'h0004, 2'b00},
    {1'b1, 4'h7, 2'd0, 13'h0000, 2'b00},
    {1'b1, 4'h7, 2'd0, 13'h0000, 2'b01}};

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] got [NDUT];
  int          n = -1;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_print = 0;
  int          last_t [NDUT] = '{-1, -1, -1, -1};
  logic [3:0]  last_p [NDUT] = '{4'h7, 4'h7, 4'h7, 4'h7};
  logic        prev_cke [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit          pinned = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gd
    ddr2_init_sequencer_if bus ();
    ddr2_init_sequencer #(
      .T_INIT(PI[g]), .T_XPR(PX[g]), .T_RP(PR[g]), .T_MRD(PM[g]), .T_RFC(PF[g]), .T_DLL(PD[g]),
      .MR_VAL(MRV), .EMR_VAL(EMRV)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .dram  (bus)
    );
    assign got[g] = {bus.cke, bus.csbar, bus.rasbar, bus.casbar, bus.webar,
                     bus.ba, bus.a, bus.odt, bus.init_done};
  end

  // Cycle index since reset release; -1 while held in reset.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= -1;
    else       n <= n + 1;
  end

  function automatic logic [21:0] model(input int g, input int c);
    logic [21:0] r;
    int gaps[11];
    int t, t_rst, t_done;
    if (c < 0) return {1'b0, 4'hF, 15'd0, 1'b0, 1'b0};
    gaps = '{PX[g], PR[g], PM[g], PM[g], PM[g], PM[g], PR[g], PF[g], PF[g], PM[g], PM[g]};
    r = {c >= PI[g], (c < PI[g]) ? 4'hF : 4'h7, 15'd0, 1'b0, 1'b0};
    t = PI[g];
    t_rst = 0;
    for (int i = 0; i < 11; i++) begin
      t += gaps[i];
      if (i == 4) t_rst = t;
      if (c == t) r[20:2] = {SEQ_PIN[i], SEQ_BA[i], SEQ_A[i]};
    end
    t_done = (t + PM[g] > t_rst + PD[g]) ? t + PM[g] : t_rst + PD[g];
    r[0] = (c >= t_done);
    return r;
  endfunction

  task automatic fail_line(input string nm, input int g, input logic [21:0] act, input logic [21:0] req);
    n_fail++;
    if (n_print < 40) begin
      n_print++;
      $display("FAIL %s dut%0d cycle %0d: got %h, required %h", nm, g, n, act, req);
    end
  endtask

  task automatic check(input string nm, input int g, input logic [21:0] act, input logic [21:0] req);
    n_chk++;
    if (act !== req) fail_line(nm, g, act, req);
  endtask

  task automatic proto(input int g);
    logic [3:0] p;
    logic       is_cmd;
    int         need;
    p = got[g][20:17];
    is_cmd = (p == 4'h2) || (p == 4'h0) || (p == 4'h1);
    if (got[g][21] !== prev_cke[g]) begin
      n_chk++;
      if (is_cmd) fail_line("cmd_on_cke_edge", g, 22'(p), 22'h7);
    end
    prev_cke[g] = got[g][21];
    if (n < 0) begin
      last_t[g] = -1;
    end else if (is_cmd) begin
      if (last_t[g] >= 0) begin
        need = (last_p[g] == 4'h2) ? PR[g] : (last_p[g] == 4'h1) ? PF[g] : PM[g];
        n_chk++;
        if (n - last_t[g] < need) fail_line("cmd_gap", g, 22'(n - last_t[g]), 22'(need));
      end
      last_t[g] = n;
      last_p[g] = p;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!pinned) begin
        pinned = 1'b1;
        for (int i = 0; i < NL; i++) check("model_pin", LG[i], model(LG[i], LC[i]), LV[i]);
      end
      for (int g = 0; g < NDUT; g++) begin
        check("pins", g, got[g], model(g, n));
        proto(g);
      end
      for (int i = 0; i < NL; i++)
        if (n == LC[i]) check("literal", LG[i], got[LG[i]], LV[i]);
    end
  end

  // Called just after a rising edge; a zero-length pulse stays within one cycle.
  task automatic pulse(input int unsigned cyc);
    #2 reset = 1'b1;
    if (cyc == 0) #2;
    else begin
      repeat (cyc) @(posedge clk);
      #2;
    end
    reset = 1'b0;
  endtask

  initial begin
    int unsigned run;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (170) @(posedge clk);
    pulse(2);
    repeat (31) @(posedge clk);
    pulse($urandom_range(1, 3));
    repeat (170) @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      run = $urandom_range(1, 80);
      repeat (run) @(posedge clk);
      pulse($urandom_range(0, 3));
    end
    repeat (170) @(posedge clk);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
